// File: rtl/pwm_multi_channel.sv
// -----------------------------------------------------------------------------
// pwm_multi_channel
//
// Multi-channel PWM generator. All channels share one prescaler and one period
// counter. The counter runs edge-aligned (sawtooth) or center-aligned
// (triangle). Period and duty writes go into pending registers. They are
// copied to the active registers only at a period boundary, so a write never
// produces a truncated or doubled pulse.
//
// Ports
//   clk        : single clock, all logic on its rising edge
//   rst_n      : asynchronous active-low reset
//   en         : global run enable (0 = idle, outputs show pol)
//   center     : 0 = edge-aligned, 1 = center-aligned
//   prescale   : counter advances once every prescale+1 clocks
//   period_we  : write strobe for the pending period
//   period_in  : period value
//   duty_we    : write strobe for one channel's pending duty
//   duty_ch    : channel index for duty_we (indices >= N_CH are ignored)
//   duty_in    : duty value
//   pol        : per-channel inversion (1 = active-low)
//   pwm_out    : registered PWM outputs
//   period_end : one-clock pulse after each period boundary
//
// Write interface: period_we / duty_we are single-cycle strobes with no
// backpressure. Data is captured on every rising edge where the strobe is
// high. There is no ready signal, and a write is never refused (except an
// out-of-range duty_ch, which is dropped).
// -----------------------------------------------------------------------------
module pwm_multi_channel #(
    parameter int N_CH  = 4,
    parameter int CNT_W = 8,
    parameter int PRE_W = 8
) (
    input  logic                                       clk,
    input  logic                                       rst_n,
    input  logic                                       en,
    input  logic                                       center,
    input  logic [PRE_W-1:0]                           prescale,
    input  logic                                       period_we,
    input  logic [CNT_W-1:0]                           period_in,
    input  logic                                       duty_we,
    input  logic [((N_CH > 1) ? $clog2(N_CH) : 1)-1:0] duty_ch,
    input  logic [CNT_W-1:0]                           duty_in,
    input  logic [N_CH-1:0]                            pol,
    output logic [N_CH-1:0]                            pwm_out,
    output logic                                       period_end
);

    logic [PRE_W-1:0] pre_q, pre_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             dir_up_q, dir_up_d;
    logic [CNT_W-1:0] period_pend_q, period_pend_d;
    logic [CNT_W-1:0] period_act_q, period_act_d;
    logic [CNT_W-1:0] duty_pend_q [N_CH];
    logic [CNT_W-1:0] duty_pend_d [N_CH];
    logic [CNT_W-1:0] duty_act_q  [N_CH];
    logic [CNT_W-1:0] duty_act_d  [N_CH];
    logic [N_CH-1:0]  pwm_q, pwm_d;
    logic             period_end_q, period_end_d;

    logic tick;
    logic boundary;
    logic update_act;

    // Prescaler and period counter.
    always_comb begin
        // '>=' rather than '==' so that lowering prescale on the fly cannot
        // strand the prescaler above the new limit for 2^PRE_W clocks.
        tick     = en && (pre_q >= prescale);
        pre_d    = '0;
        cnt_d    = cnt_q;
        dir_up_d = dir_up_q;
        boundary = 1'b0;

        if (!en) begin
            cnt_d    = '0;
            dir_up_d = 1'b1;
        end else begin
            pre_d = tick ? '0 : pre_q + 1'b1;
            if (tick) begin
                if (period_act_q == '0) begin
                    // Degenerate period: every tick is a boundary.
                    cnt_d    = '0;
                    dir_up_d = 1'b1;
                    boundary = 1'b1;
                end else if (!center) begin
                    dir_up_d = 1'b1;
                    // '>=' also covers cnt above a freshly shrunk period.
                    if (cnt_q >= period_act_q) begin
                        cnt_d    = '0;
                        boundary = 1'b1;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end else if (dir_up_q && (cnt_q < period_act_q)) begin
                    cnt_d = cnt_q + 1'b1;
                end else begin
                    // Turn point or descending slope. At the top the count
                    // steps straight down, so the peak is not repeated.
                    if (cnt_q <= CNT_W'(1)) begin
                        cnt_d    = '0;
                        dir_up_d = 1'b1;
                        boundary = 1'b1;
                    end else begin
                        cnt_d    = cnt_q - 1'b1;
                        dir_up_d = 1'b0;
                    end
                end
            end
        end
    end

    // Shadow registers and output compare.
    assign update_act = !en || boundary;

    always_comb begin
        period_pend_d = period_we ? period_in : period_pend_q;
        // Active takes the pending value from before this edge. A write that
        // lands on a boundary is therefore applied one boundary later.
        period_act_d  = update_act ? period_pend_q : period_act_q;
        for (int i = 0; i < N_CH; i++) begin
            duty_pend_d[i] = (duty_we && (int'(duty_ch) == i)) ? duty_in : duty_pend_q[i];
            duty_act_d[i]  = update_act ? duty_pend_q[i] : duty_act_q[i];
            pwm_d[i]       = en ? ((cnt_q < duty_act_q[i]) ^ pol[i]) : pol[i];
        end
        period_end_d = boundary;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pre_q         <= '0;
            cnt_q         <= '0;
            dir_up_q      <= 1'b1;
            period_pend_q <= '1;
            period_act_q  <= '1;
            for (int i = 0; i < N_CH; i++) begin
                duty_pend_q[i] <= '0;
                duty_act_q[i]  <= '0;
            end
            pwm_q         <= '0;
            period_end_q  <= 1'b0;
        end else begin
            pre_q         <= pre_d;
            cnt_q         <= cnt_d;
            dir_up_q      <= dir_up_d;
            period_pend_q <= period_pend_d;
            period_act_q  <= period_act_d;
            for (int i = 0; i < N_CH; i++) begin
                duty_pend_q[i] <= duty_pend_d[i];
                duty_act_q[i]  <= duty_act_d[i];
            end
            pwm_q         <= pwm_d;
            period_end_q  <= period_end_d;
        end
    end

    assign pwm_out    = pwm_q;
    assign period_end = period_end_q;

endmodule

// File: tb/tb_pwm_multi_channel.sv
// -----------------------------------------------------------------------------
// tb_pwm_multi_channel
//
// Bench for pwm_multi_channel with N_CH=3, so that duty_ch=3 is an
// out-of-range index. Each measurement window runs from one period_end sample
// up to the next one. It records the window length in clocks, and the number
// of high clocks and rising edges of one channel.
//
// pwm_out lags cnt by one clock. Sample t0 of a window therefore still shows
// the last count of the previous period, evaluated with the previous duty.
// -----------------------------------------------------------------------------
module tb_pwm_multi_channel;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       en;
    logic       center;
    logic [7:0] prescale;
    logic       period_we;
    logic [7:0] period_in;
    logic       duty_we;
    logic [1:0] duty_ch;
    logic [7:0] duty_in;
    logic [2:0] pol;
    logic [2:0] pwm_out;
    logic       period_end;

    logic [15:0] exp_q[$];
    int n_vec = 0;
    int n_err = 0;

    pwm_multi_channel #(.N_CH(3), .CNT_W(8), .PRE_W(8)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .en         (en),
        .center     (center),
        .prescale   (prescale),
        .period_we  (period_we),
        .period_in  (period_in),
        .duty_we    (duty_we),
        .duty_ch    (duty_ch),
        .duty_in    (duty_in),
        .pol        (pol),
        .pwm_out    (pwm_out),
        .period_end (period_end)
    );

    // ---------------- clock ----------------
    always #5 clk = ~clk;

    // ---------------- checking ----------------
    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
        end
    endtask

    // Pops the next expected value. An empty queue yields 16'hFFFF, which no
    // measured quantity can match, so the comparison fails.
    task automatic pop_check(input string tag, input logic [31:0] got);
        logic [15:0] e;
        e = (exp_q.size() == 0) ? 16'hFFFF : exp_q.pop_front();
        check_val(tag, got, 32'(e));
    endtask

    task automatic expect_period(input int len, input int high, input int rises);
        exp_q.push_back(16'(len));
        exp_q.push_back(16'(high));
        exp_q.push_back(16'(rises));
    endtask

    // ---------------- drivers ----------------
    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic write_period(input logic [7:0] v);
        period_we = 1'b1;
        period_in = v;
        @(negedge clk);
        period_we = 1'b0;
    endtask

    task automatic write_duty(input logic [1:0] ch, input logic [7:0] v);
        duty_we = 1'b1;
        duty_ch = ch;
        duty_in = v;
        @(negedge clk);
        duty_we = 1'b0;
    endtask

    // Advance to the next period_end sample (at least one clock).
    task automatic next_end(input string tag);
        int n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (period_end !== 1'b1 && n < 2000);
        if (n >= 2000) check_val({tag, "_timeout"}, 0, 1);
    endtask

    // Clocks from en (or reset release) to the first period_end sample.
    task automatic start_lat(input string tag);
        int n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (period_end !== 1'b1 && n < 3000);
        pop_check(tag, n);
    endtask

    // Measure one window. If wr_at >= 0, a duty write to channel ch is issued
    // at sample wr_at of the window.
    task automatic measure(input int ch, input int wr_at, input logic [7:0] wr_val,
                           input string tag);
        int   len   = 0;
        int   high  = 0;
        int   rises = 0;
        int   sync  = 0;
        logic prev  = 1'b0;
        while (period_end !== 1'b1 && sync < 2000) begin
            @(negedge clk);
            sync++;
        end
        do begin
            if (pwm_out[ch] === 1'b1) high++;
            if (len > 0 && pwm_out[ch] === 1'b1 && prev === 1'b0) rises++;
            prev = pwm_out[ch];
            if (len == wr_at) begin
                duty_we = 1'b1;
                duty_ch = 2'(ch);
                duty_in = wr_val;
            end else begin
                duty_we = 1'b0;
            end
            len++;
            @(negedge clk);
        end while (period_end !== 1'b1 && len < 2000);
        duty_we = 1'b0;
        pop_check({tag, "_len"}, len);
        pop_check({tag, "_high"}, high);
        pop_check({tag, "_rises"}, rises);
    endtask

    // ---------------- watchdog ----------------
    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // ---------------- stimulus ----------------
    initial begin
        rst_n = 1'b0; en = 1'b0; center = 1'b0; prescale = 8'd0;
        period_we = 1'b0; period_in = 8'd0; duty_we = 1'b0; duty_ch = 2'd0;
        duty_in = 8'd0; pol = 3'b000;

        // Reset state
        idle(2);
        check_val("rst_pwm", 32'(pwm_out), 0);
        check_val("rst_pe", 32'(period_end), 0);
        rst_n = 1'b1;

        // Idle: outputs follow pol
        pol = 3'b101;
        idle(2);
        check_val("idle_pol", 32'(pwm_out), 5);
        check_val("idle_pe", 32'(period_end), 0);
        pol = 3'b000;

        // Edge mode, period 9, duty0 5, prescale 0
        write_period(8'd9);
        write_duty(2'd0, 8'd5);
        idle(2);
        exp_q.push_back(16'd10);
        en = 1'b1;
        start_lat("start_edge");
        expect_period(10, 5, 1);  measure(0, -1, 8'd0, "edge_ch0");
        expect_period(10, 0, 0);  measure(2, -1, 8'd0, "edge_ch2_zero");

        // Shadowing: mid-period write shows up only after the next boundary
        expect_period(10, 5, 1);  measure(0, 3, 8'd7, "shadow_mid");
        expect_period(10, 7, 1);  measure(0, -1, 8'd0, "shadow_new");
        // A write on the boundary clock is applied one boundary later
        expect_period(10, 7, 1);  measure(0, 9, 8'd5, "bnd_wr");
        expect_period(10, 7, 1);  measure(0, -1, 8'd0, "bnd_old");
        expect_period(10, 5, 1);  measure(0, -1, 8'd0, "bnd_new");

        // Out-of-range channel index changes nothing
        write_duty(2'd3, 8'd200);
        next_end("bad_idx");
        expect_period(10, 0, 0);  measure(2, -1, 8'd0, "bad_idx_ch2");
        expect_period(10, 0, 0);  measure(1, -1, 8'd0, "bad_idx_ch1");
        expect_period(10, 5, 1);  measure(0, -1, 8'd0, "bad_idx_ch0");

        // duty = period+1: constant high. The first window's t0 still uses
        // the old duty (0), hence 9 high clocks and one rise.
        write_duty(2'd1, 8'd10);
        next_end("full");
        expect_period(10, 9, 1);  measure(1, -1, 8'd0, "full_first");
        expect_period(10, 10, 0); measure(1, -1, 8'd0, "full_steady");

        // Polarity inverts both extremes
        pol = 3'b110;
        next_end("pol");
        expect_period(10, 0, 0);  measure(1, -1, 8'd0, "pol_full");
        expect_period(10, 10, 0); measure(2, -1, 8'd0, "pol_zero");
        pol = 3'b000;

        // Center mode: period 8, prescale 1 -> 32 clocks per period.
        // ch1 duty 2: counts 1(down),0,1(up) -> 3 ticks = 6 clocks high.
        // ch0 duty 5: counts 0..4 up and 4..1 down -> 9 ticks = 18 clocks.
        en = 1'b0;
        idle(1);
        write_period(8'd8);
        write_duty(2'd1, 8'd2);
        prescale = 8'd1;
        center = 1'b1;
        idle(2);
        exp_q.push_back(16'd32);
        en = 1'b1;
        start_lat("start_ctr");
        expect_period(32, 6, 1);  measure(1, -1, 8'd0, "ctr_ch1");
        expect_period(32, 18, 1); measure(0, -1, 8'd0, "ctr_ch0");

        // Period 0: every tick is a boundary
        en = 1'b0;
        write_period(8'd0);
        center = 1'b0;
        prescale = 8'd0;
        idle(2);
        exp_q.push_back(16'd1);
        en = 1'b1;
        start_lat("start_p0");
        expect_period(1, 1, 0);   measure(0, -1, 8'd0, "p0_ch0_a");
        expect_period(1, 1, 0);   measure(0, -1, 8'd0, "p0_ch0_b");
        expect_period(1, 0, 0);   measure(2, -1, 8'd0, "p0_ch2");
        prescale = 8'd2;
        next_end("p0_pre2");
        expect_period(3, 3, 0);   measure(0, -1, 8'd0, "p0_pre2");

        // Reset mid-period with en=1
        en = 1'b0;
        prescale = 8'd0;
        write_period(8'd9);
        idle(2);
        exp_q.push_back(16'd10);
        en = 1'b1;
        start_lat("start_edge2");
        idle(3);
        check_val("pre_rst_pwm0", 32'(pwm_out[0]), 1);
        #2;
        rst_n = 1'b0;
        #1;
        check_val("rst_mid_pwm", 32'(pwm_out), 0);
        check_val("rst_mid_pe", 32'(period_end), 0);
        @(negedge clk);
        exp_q.push_back(16'd256);
        rst_n = 1'b1;
        start_lat("start_after_rst");
        expect_period(256, 0, 0); measure(0, -1, 8'd0, "post_rst");

        check_val("sb_drain", 32'(exp_q.size()), 0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
